// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit
// Pipeline control for the five-stage CPU. This block decodes the IF/ID
// instruction into a control word. It carries that word through the
// ID/EX, EX/MEM and MEM/WB control registers. From that state it drives
// the per-stage controls, the operand forwarding selects, the load-use
// stall and the branch flush. The stall, flush and forwarding outputs are
// combinational from the current register state, so they add no latency.
module pipe_ctrl_unit #(
    parameter int ALUOP_W        = 4,
    parameter int REG_AW         = 5,
    parameter int BRANCH_IN_MEM  = 1,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        ifid_inst,
    input  logic               ext_stall,
    input  logic               branch_taken,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ifid_flush,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_use_imm,
    output logic               ex_shift,
    output logic               ex_sign_ext,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic               mem_write,
    output logic               mem_branch,
    output logic               wb_reg_write,
    output logic               wb_mem_to_reg,
    output logic [REG_AW-1:0]  wb_dest
);

    // ALU operation codes shared with the datapath ALU
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(4'd0);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(4'd1);
    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(4'd2);
    localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(4'd3);
    localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(4'd4);
    localparam logic [ALUOP_W-1:0] ALU_SRA = ALUOP_W'(4'd5);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(4'd6);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4'd7);
    localparam logic [ALUOP_W-1:0] ALU_NOR = ALUOP_W'(4'd12);

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Full control word held in ID/EX
    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               use_imm;
        logic               shift;
        logic               sign_ext;
        logic               mem_write;
        logic               branch;
        logic               mem_read;
        logic               reg_write;
        logic               mem_to_reg;
        logic [REG_AW-1:0]  dest;
        logic [REG_AW-1:0]  rs;
        logic [REG_AW-1:0]  rt;
    } idex_t;

    // Subset still needed once the instruction leaves EX
    typedef struct packed {
        logic              mem_write;
        logic              branch;
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_AW-1:0] dest;
    } exmem_t;

    // Subset still needed in write-back
    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_AW-1:0] dest;
    } memwb_t;

    // Forwarding source for one EX operand. A hit in EX/MEM is the younger
    // result, so it wins over a hit in MEM/WB. Register 0 is never forwarded.
    function automatic logic [1:0] fwd_select(
        input logic [REG_AW-1:0] src,
        input exmem_t            em,
        input memwb_t            mw
    );
        logic [1:0] sel;
        if (src == '0) begin
            sel = 2'b00;
        end else if (em.reg_write && (em.dest == src)) begin
            sel = 2'b10;
        end else if (mw.reg_write && (mw.dest == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    logic [5:0]        opcode_s;
    logic [5:0]        funct_s;
    logic [REG_AW-1:0] rs_s;
    logic [REG_AW-1:0] rt_s;
    logic [REG_AW-1:0] rd_s;
    logic              unused_s;

    idex_t             dec_s;
    idex_t             dec_word_s;
    logic              dec_ok_s;
    logic              dec_writes_s;
    logic              reads_rt_s;
    logic              load_use_s;
    logic              resolve_branch_s;
    logic              taken_s;
    logic              hold_s;
    logic              idex_bubble_s;
    logic              exmem_bubble_s;

    idex_t             idex_r;
    idex_t             idex_n_s;
    exmem_t            exmem_r;
    exmem_t            exmem_n_s;
    memwb_t            memwb_r;
    memwb_t            memwb_n_s;

    assign opcode_s = ifid_inst[31:26];
    assign funct_s  = ifid_inst[5:0];
    assign rs_s     = REG_AW'(ifid_inst[25:21]);
    assign rt_s     = REG_AW'(ifid_inst[20:16]);
    assign rd_s     = REG_AW'(ifid_inst[15:11]);
    // The shift amount and immediate go straight to the datapath
    assign unused_s = ^ifid_inst[10:6];

    // Decode the IF/ID instruction into a raw control word and a validity flag
    always_comb begin
        dec_s        = '0;
        dec_ok_s     = 1'b1;
        dec_writes_s = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                dec_writes_s = 1'b1;
                dec_s.dest   = rd_s;
                case (funct_s)
                    FN_ADD:  dec_s.alu_op = ALU_ADD;
                    FN_SUB:  dec_s.alu_op = ALU_SUB;
                    FN_AND:  dec_s.alu_op = ALU_AND;
                    FN_OR:   dec_s.alu_op = ALU_OR;
                    FN_NOR:  dec_s.alu_op = ALU_NOR;
                    FN_SLT:  dec_s.alu_op = ALU_SLT;
                    FN_SLL: begin
                        dec_s.alu_op = ALU_SLL;
                        dec_s.shift  = 1'b1;
                    end
                    FN_SRL: begin
                        dec_s.alu_op = ALU_SRL;
                        dec_s.shift  = 1'b1;
                    end
                    FN_SRA: begin
                        dec_s.alu_op = ALU_SRA;
                        dec_s.shift  = 1'b1;
                    end
                    default: dec_ok_s = 1'b0;
                endcase
            end
            OP_ADDI: begin
                dec_s.alu_op   = ALU_ADD;
                dec_s.use_imm  = 1'b1;
                dec_s.sign_ext = 1'b1;
                dec_s.dest     = rt_s;
                dec_writes_s   = 1'b1;
            end
            OP_ANDI: begin
                dec_s.alu_op  = ALU_AND;
                dec_s.use_imm = 1'b1;
                dec_s.dest    = rt_s;
                dec_writes_s  = 1'b1;
            end
            OP_ORI: begin
                dec_s.alu_op  = ALU_OR;
                dec_s.use_imm = 1'b1;
                dec_s.dest    = rt_s;
                dec_writes_s  = 1'b1;
            end
            OP_LW: begin
                dec_s.alu_op     = ALU_ADD;
                dec_s.use_imm    = 1'b1;
                dec_s.sign_ext   = 1'b1;
                dec_s.mem_read   = 1'b1;
                dec_s.mem_to_reg = 1'b1;
                dec_s.dest       = rt_s;
                dec_writes_s     = 1'b1;
            end
            OP_SW: begin
                dec_s.alu_op    = ALU_ADD;
                dec_s.use_imm   = 1'b1;
                dec_s.sign_ext  = 1'b1;
                dec_s.mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec_s.alu_op   = ALU_SUB;
                dec_s.sign_ext = 1'b1;
                dec_s.branch   = 1'b1;
            end
            default: dec_ok_s = 1'b0;
        endcase
        dec_s.rs        = rs_s;
        dec_s.rt        = rt_s;
        // Writes to $0 are discarded, so do not let them forward or hazard
        dec_s.reg_write = dec_writes_s && (dec_s.dest != '0);
    end

    // An unrecognised instruction becomes a bubble
    always_comb begin
        if (dec_ok_s) begin
            dec_word_s = dec_s;
        end else begin
            dec_word_s = '0;
        end
    end

    // Flag the instructions that read rt as a register source
    always_comb begin
        case (opcode_s)
            OP_RTYPE, OP_SW, OP_BEQ: reads_rt_s = 1'b1;
            default:                 reads_rt_s = 1'b0;
        endcase
    end

    // Detect a load in EX whose result the IF/ID instruction needs next cycle
    always_comb begin
        load_use_s = 1'b0;
        if ((LOAD_USE_STALL != 0) && idex_r.mem_read && (idex_r.dest != '0)) begin
            if (idex_r.dest == rs_s) begin
                load_use_s = 1'b1;
            end else if (reads_rt_s && (idex_r.dest == rt_s)) begin
                load_use_s = 1'b1;
            end else begin
                load_use_s = 1'b0;
            end
        end else begin
            load_use_s = 1'b0;
        end
    end

    // Select the branch bit of the stage that resolves the branch
    always_comb begin
        if (BRANCH_IN_MEM != 0) begin
            resolve_branch_s = exmem_r.branch;
        end else begin
            resolve_branch_s = idex_r.branch;
        end
    end

    // A memory wait masks the branch result for the whole cycle
    assign taken_s = branch_taken && resolve_branch_s && !ext_stall;

    // Pipeline steering: freeze, then flush, then load-use stall, then advance
    always_comb begin
        pc_write       = 1'b1;
        ifid_write     = 1'b1;
        ifid_flush     = 1'b0;
        hold_s         = 1'b0;
        idex_bubble_s  = 1'b0;
        exmem_bubble_s = 1'b0;
        if (ext_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            hold_s     = 1'b1;
        end else if (taken_s) begin
            ifid_flush     = 1'b1;
            idex_bubble_s  = 1'b1;
            exmem_bubble_s = (BRANCH_IN_MEM != 0);
        end else if (load_use_s) begin
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            idex_bubble_s = 1'b1;
        end else begin
            hold_s = 1'b0;
        end
    end

    // Next contents of the three control registers
    always_comb begin
        idex_n_s  = idex_r;
        exmem_n_s = exmem_r;
        memwb_n_s = memwb_r;
        if (!hold_s) begin
            memwb_n_s.reg_write  = exmem_r.reg_write;
            memwb_n_s.mem_to_reg = exmem_r.mem_to_reg;
            memwb_n_s.dest       = exmem_r.dest;
            if (exmem_bubble_s) begin
                exmem_n_s = '0;
            end else begin
                exmem_n_s.mem_write  = idex_r.mem_write;
                exmem_n_s.branch     = idex_r.branch;
                exmem_n_s.reg_write  = idex_r.reg_write;
                exmem_n_s.mem_to_reg = idex_r.mem_to_reg;
                exmem_n_s.dest       = idex_r.dest;
            end
            if (idex_bubble_s) begin
                idex_n_s = '0;
            end else begin
                idex_n_s = dec_word_s;
            end
        end else begin
            memwb_n_s = memwb_r;
        end
    end

    // ID/EX control register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idex_r <= '0;
        end else begin
            idex_r <= idex_n_s;
        end
    end

    // EX/MEM control register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exmem_r <= '0;
        end else begin
            exmem_r <= exmem_n_s;
        end
    end

    // MEM/WB control register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            memwb_r <= '0;
        end else begin
            memwb_r <= memwb_n_s;
        end
    end

    // Operand forwarding selects for the instruction in EX
    always_comb begin
        fwd_a = fwd_select(idex_r.rs, exmem_r, memwb_r);
        fwd_b = fwd_select(idex_r.rt, exmem_r, memwb_r);
    end

    assign ex_alu_op     = idex_r.alu_op;
    assign ex_use_imm    = idex_r.use_imm;
    assign ex_shift      = idex_r.shift;
    assign ex_sign_ext   = idex_r.sign_ext;
    assign mem_write     = exmem_r.mem_write;
    assign mem_branch    = exmem_r.branch;
    assign wb_reg_write  = memwb_r.reg_write;
    assign wb_mem_to_reg = memwb_r.mem_to_reg;
    assign wb_dest       = memwb_r.dest;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit. It runs two instances side by side on the same
// inputs: index 0 resolves branches in EX and index 1 resolves them in MEM.
// A behavioural model of the control words in flight predicts every output.
module tb_pipe_ctrl_unit;

    localparam logic [3:0] A_AND = 4'd0,  A_OR  = 4'd1, A_ADD = 4'd2,
                           A_SLL = 4'd3,  A_SRL = 4'd4, A_SRA = 4'd5,
                           A_SUB = 4'd6,  A_SLT = 4'd7, A_NOR = 4'd12;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_ANDI = 6'h0C,
                           OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [3:0] alu_op;
        logic use_imm, shift, sign_ext, mem_write, branch, mem_read, reg_write, mem_to_reg;
        logic [4:0] dest, rs, rt;
    } cw_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ifid_inst;
    logic        ext_stall;
    logic        branch_taken;

    logic [1:0] pc_write_w, ifid_write_w, ifid_flush_w, use_imm_w, shift_w, sext_w;
    logic [1:0] mem_write_w, mem_branch_w, wb_rw_w, wb_m2r_w;
    logic [3:0] alu_w   [2];
    logic [1:0] fwd_a_w [2];
    logic [1:0] fwd_b_w [2];
    logic [4:0] dest_w  [2];

    cw_t m_ex [2];
    cw_t m_mem[2];
    cw_t m_wb [2];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    pipe_ctrl_unit #(.ALUOP_W(4), .REG_AW(5), .BRANCH_IN_MEM(0), .LOAD_USE_STALL(1)) dut_ex (
        .clock(clock), .reset(reset), .ifid_inst(ifid_inst), .ext_stall(ext_stall),
        .branch_taken(branch_taken), .pc_write(pc_write_w[0]), .ifid_write(ifid_write_w[0]),
        .ifid_flush(ifid_flush_w[0]), .ex_alu_op(alu_w[0]), .ex_use_imm(use_imm_w[0]),
        .ex_shift(shift_w[0]), .ex_sign_ext(sext_w[0]), .fwd_a(fwd_a_w[0]), .fwd_b(fwd_b_w[0]),
        .mem_write(mem_write_w[0]), .mem_branch(mem_branch_w[0]), .wb_reg_write(wb_rw_w[0]),
        .wb_mem_to_reg(wb_m2r_w[0]), .wb_dest(dest_w[0]));

    pipe_ctrl_unit #(.ALUOP_W(4), .REG_AW(5), .BRANCH_IN_MEM(1), .LOAD_USE_STALL(1)) dut_mem (
        .clock(clock), .reset(reset), .ifid_inst(ifid_inst), .ext_stall(ext_stall),
        .branch_taken(branch_taken), .pc_write(pc_write_w[1]), .ifid_write(ifid_write_w[1]),
        .ifid_flush(ifid_flush_w[1]), .ex_alu_op(alu_w[1]), .ex_use_imm(use_imm_w[1]),
        .ex_shift(shift_w[1]), .ex_sign_ext(sext_w[1]), .fwd_a(fwd_a_w[1]), .fwd_b(fwd_b_w[1]),
        .mem_write(mem_write_w[1]), .mem_branch(mem_branch_w[1]), .wb_reg_write(wb_rw_w[1]),
        .wb_mem_to_reg(wb_m2r_w[1]), .wb_dest(dest_w[1]));

    function automatic logic [31:0] rtype(logic [5:0] fn, logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Reference decode, written from the instruction set description
    function automatic cw_t ref_decode(logic [31:0] i);
        cw_t c;
        logic ok, wr;
        c = '0; ok = 1'b1; wr = 1'b0;
        if (i[31:26] == 6'h00) begin
            wr = 1'b1;
            c.dest = i[15:11];
            case (i[5:0])
                6'h20: c.alu_op = A_ADD;
                6'h22: c.alu_op = A_SUB;
                6'h24: c.alu_op = A_AND;
                6'h25: c.alu_op = A_OR;
                6'h27: c.alu_op = A_NOR;
                6'h2A: c.alu_op = A_SLT;
                6'h00: begin c.alu_op = A_SLL; c.shift = 1'b1; end
                6'h02: begin c.alu_op = A_SRL; c.shift = 1'b1; end
                6'h03: begin c.alu_op = A_SRA; c.shift = 1'b1; end
                default: ok = 1'b0;
            endcase
        end else begin
            case (i[31:26])
                OP_ADDI: begin c.alu_op = A_ADD; c.use_imm = 1'b1; c.sign_ext = 1'b1; wr = 1'b1; end
                OP_ANDI: begin c.alu_op = A_AND; c.use_imm = 1'b1; wr = 1'b1; end
                OP_ORI:  begin c.alu_op = A_OR;  c.use_imm = 1'b1; wr = 1'b1; end
                OP_LW:   begin c.alu_op = A_ADD; c.use_imm = 1'b1; c.sign_ext = 1'b1; wr = 1'b1;
                               c.mem_read = 1'b1; c.mem_to_reg = 1'b1; end
                OP_SW:   begin c.alu_op = A_ADD; c.use_imm = 1'b1; c.sign_ext = 1'b1; c.mem_write = 1'b1; end
                OP_BEQ:  begin c.alu_op = A_SUB; c.sign_ext = 1'b1; c.branch = 1'b1; end
                default: ok = 1'b0;
            endcase
            if (wr) c.dest = i[20:16];
        end
        c.reg_write = wr && (c.dest != 5'd0);
        c.rs = i[25:21];
        c.rt = i[20:16];
        if (!ok) c = '0;
        return c;
    endfunction

    function automatic logic ref_taken(int b);
        return !ext_stall && branch_taken && ((b == 1) ? m_mem[b].branch : m_ex[b].branch);
    endfunction

    function automatic logic ref_hazard(int b);
        logic reads_rt;
        reads_rt = (ifid_inst[31:26] == 6'h00) || (ifid_inst[31:26] == OP_SW) || (ifid_inst[31:26] == OP_BEQ);
        return m_ex[b].mem_read && (m_ex[b].dest != 5'd0) &&
               ((m_ex[b].dest == ifid_inst[25:21]) || (reads_rt && (m_ex[b].dest == ifid_inst[20:16])));
    endfunction

    function automatic logic [1:0] ref_fwd(int b, logic [4:0] src);
        if (src != 5'd0 && m_mem[b].reg_write && m_mem[b].dest == src) return 2'b10;
        if (src != 5'd0 && m_wb[b].reg_write && m_wb[b].dest == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(string tag, int b, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, b, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_ex[b] = '0; m_mem[b] = '0; m_wb[b] = '0;
        end
    endtask

    task automatic check_outputs();
        for (int b = 0; b < 2; b++) begin
            logic t, h;
            t = ref_taken(b);
            h = ref_hazard(b);
            chk("pc_write",   b, pc_write_w[b],   !ext_stall && (t || !h));
            chk("ifid_write", b, ifid_write_w[b], !ext_stall && (t || !h));
            chk("ifid_flush", b, ifid_flush_w[b], t);
            chk("ex_alu_op",  b, alu_w[b],        m_ex[b].alu_op);
            chk("ex_use_imm", b, use_imm_w[b],    m_ex[b].use_imm);
            chk("ex_shift",   b, shift_w[b],      m_ex[b].shift);
            chk("ex_sign_ext",b, sext_w[b],       m_ex[b].sign_ext);
            chk("fwd_a",      b, fwd_a_w[b],      ref_fwd(b, m_ex[b].rs));
            chk("fwd_b",      b, fwd_b_w[b],      ref_fwd(b, m_ex[b].rt));
            chk("mem_write",  b, mem_write_w[b],  m_mem[b].mem_write);
            chk("mem_branch", b, mem_branch_w[b], m_mem[b].branch);
            chk("wb_reg_write",  b, wb_rw_w[b],   m_wb[b].reg_write);
            chk("wb_mem_to_reg", b, wb_m2r_w[b],  m_wb[b].mem_to_reg);
            chk("wb_dest",    b, dest_w[b],       m_wb[b].dest);
        end
    endtask

    task automatic model_advance();
        if (!reset) begin
            model_reset();
        end else if (!ext_stall) begin
            for (int b = 0; b < 2; b++) begin
                logic t, h;
                t = ref_taken(b);
                h = ref_hazard(b);
                m_wb[b]  = m_mem[b];
                m_mem[b] = (t && b == 1) ? '0 : m_ex[b];
                m_ex[b]  = (t || h) ? '0 : ref_decode(ifid_inst);
            end
        end
    endtask

    // One clock: check at the falling edge, then step the model with the DUT
    task automatic cycle();
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        model_advance();
        #1;
    endtask

    task automatic drive(logic [31:0] i, logic st, logic bt);
        ifid_inst = i; ext_stall = st; branch_taken = bt;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0] fns [9];
        logic [4:0] a, c, d;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03};
        a = 5'($urandom_range(0, 3));
        c = 5'($urandom_range(0, 3));
        d = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 8))
            0, 1: return rtype(fns[$urandom_range(0, 8)], d, a, c);
            2: return itype(OP_ADDI, a, c, 16'($urandom));
            3: return itype(OP_ANDI, a, c, 16'($urandom));
            4: return itype(OP_ORI,  a, c, 16'($urandom));
            5: return itype(OP_LW,   a, c, 16'($urandom));
            6: return itype(OP_SW,   a, c, 16'($urandom));
            7: return itype(OP_BEQ,  a, c, 16'($urandom));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        reset = 1'b0;
        drive($urandom, 1'b0, 1'b0);
        // Held in reset with random instructions
        repeat (3) begin
            ifid_inst = $urandom;
            cycle();
        end
        chk("rst_pc_write", 1, pc_write_w[1], 1);
        chk("rst_ifid_write", 0, ifid_write_w[0], 1);
        chk("rst_ex_alu_op", 1, alu_w[1], 0);

        // Release, then ADD $3,$1,$2 flows to write-back
        reset = 1'b1;
        drive(rtype(6'h20, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0);
        cycle();
        chk("add_ex_alu_op", 0, alu_w[0], A_ADD);
        chk("add_ex_alu_op", 1, alu_w[1], A_ADD);
        drive(NOP, 1'b0, 1'b0);
        cycle(); cycle();
        chk("add_wb_reg_write", 1, wb_rw_w[1], 1);
        chk("add_wb_dest", 1, dest_w[1], 3);
        cycle();

        // Forwarding from EX/MEM, from MEM/WB, never from $0, EX/MEM first
        drive(rtype(6'h20, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0); cycle();
        drive(rtype(6'h22, 5'd4, 5'd3, 5'd3), 1'b0, 1'b0); cycle();
        chk("fwd_a_exmem", 1, fwd_a_w[1], 2'b10);
        chk("fwd_b_exmem", 0, fwd_b_w[0], 2'b10);
        drive(NOP, 1'b0, 1'b0); cycle(); cycle(); cycle();
        drive(rtype(6'h20, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0); cycle();
        drive(NOP, 1'b0, 1'b0); cycle();
        drive(rtype(6'h22, 5'd4, 5'd3, 5'd3), 1'b0, 1'b0); cycle();
        chk("fwd_a_memwb", 1, fwd_a_w[1], 2'b01);
        chk("fwd_b_memwb", 1, fwd_b_w[1], 2'b01);
        drive(rtype(6'h20, 5'd0, 5'd1, 5'd2), 1'b0, 1'b0); cycle();
        drive(rtype(6'h22, 5'd4, 5'd0, 5'd0), 1'b0, 1'b0); cycle();
        chk("fwd_a_zero", 1, fwd_a_w[1], 2'b00);
        drive(rtype(6'h20, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0); cycle();
        drive(rtype(6'h20, 5'd3, 5'd2, 5'd2), 1'b0, 1'b0); cycle();
        drive(rtype(6'h22, 5'd4, 5'd3, 5'd3), 1'b0, 1'b0); cycle();
        chk("fwd_a_double", 1, fwd_a_w[1], 2'b10);
        drive(NOP, 1'b0, 1'b0); cycle(); cycle(); cycle();

        // Load-use: LW $5,0($1) then ADD $6,$5,$2
        drive(itype(OP_LW, 5'd1, 5'd5, 16'd0), 1'b0, 1'b0); cycle();
        drive(rtype(6'h20, 5'd6, 5'd5, 5'd2), 1'b0, 1'b0); #1;
        chk("lu_pc_write", 1, pc_write_w[1], 0);
        chk("lu_ifid_write", 0, ifid_write_w[0], 0);
        cycle();
        chk("lu_bubble", 1, alu_w[1], 0);
        chk("lu_pc_write_after", 1, pc_write_w[1], 1);
        cycle();
        chk("lu_fwd_a", 1, fwd_a_w[1], 2'b01);
        chk("lu_add_in_ex", 1, alu_w[1], A_ADD);
        drive(NOP, 1'b0, 1'b0); cycle(); cycle(); cycle();

        // Taken branch in EX (index 0), then in MEM (index 1)
        drive(itype(OP_BEQ, 5'd1, 5'd2, 16'd4), 1'b0, 1'b0); cycle();
        drive(itype(OP_SW, 5'd2, 5'd1, 16'd0), 1'b0, 1'b1); #1;
        chk("br_ex_flush", 0, ifid_flush_w[0], 1);
        chk("br_mem_noflush", 1, ifid_flush_w[1], 0);
        cycle();
        chk("br_ex_bubble_alu", 0, alu_w[0], 0);
        chk("br_ex_bubble_imm", 0, use_imm_w[0], 0);
        drive(rtype(6'h20, 5'd7, 5'd1, 5'd2), 1'b0, 1'b1); #1;
        chk("br_mem_flush", 1, ifid_flush_w[1], 1);
        chk("br_mem_pc_write", 1, pc_write_w[1], 1);
        chk("br_ex_noflush", 0, ifid_flush_w[0], 0);
        cycle();
        chk("br_mem_killed_sw", 1, mem_write_w[1], 0);
        chk("br_mem_bubble_alu", 1, alu_w[1], 0);
        drive(NOP, 1'b0, 1'b0); cycle();
        chk("br_mem_killed_wb", 1, wb_rw_w[1], 0);
        cycle(); cycle(); cycle();

        // Memory wait over a taken branch and a load-use hazard
        drive(itype(OP_BEQ, 5'd1, 5'd2, 16'd4), 1'b0, 1'b0); cycle();
        drive(itype(OP_LW, 5'd1, 5'd5, 16'd0), 1'b0, 1'b0); cycle();
        drive(rtype(6'h20, 5'd6, 5'd5, 5'd2), 1'b1, 1'b1); #1;
        chk("pri_pc_write", 1, pc_write_w[1], 0);
        chk("pri_ifid_write", 1, ifid_write_w[1], 0);
        chk("pri_noflush", 1, ifid_flush_w[1], 0);
        cycle();
        chk("pri_hold_branch", 1, mem_branch_w[1], 1);
        chk("pri_hold_load", 1, alu_w[1], A_ADD);
        drive(rtype(6'h20, 5'd6, 5'd5, 5'd2), 1'b0, 1'b1); #1;
        chk("pri_flush", 1, ifid_flush_w[1], 1);
        chk("pri_no_stall", 1, pc_write_w[1], 1);
        chk("pri_ex_stall", 0, pc_write_w[0], 0);
        cycle();
        chk("pri_exmem_bubble", 1, mem_branch_w[1], 0);
        drive(NOP, 1'b0, 1'b0); cycle(); cycle(); cycle();

        // Unknown opcode and unknown funct become bubbles
        drive(32'hFC22_1820, 1'b0, 1'b0); cycle();
        chk("unk_op_alu", 1, alu_w[1], 0);
        chk("unk_op_imm", 0, use_imm_w[0], 0);
        drive(rtype(6'h3F, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0); cycle();
        chk("unk_fn_alu", 1, alu_w[1], 0);
        chk("unk_fn_shift", 1, shift_w[1], 0);

        // Reset asserted between edges clears all stages at once
        drive(rtype(6'h20, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0); cycle();
        drive(itype(OP_LW, 5'd1, 5'd5, 16'd0), 1'b0, 1'b0); cycle();
        drive(itype(OP_SW, 5'd2, 5'd1, 16'd0), 1'b0, 1'b0); cycle();
        chk("pre_rst_wb", 1, wb_rw_w[1], 1);
        chk("pre_rst_imm", 1, use_imm_w[1], 1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_rst_wb", 1, wb_rw_w[1], 0);
        chk("async_rst_dest", 0, dest_w[0], 0);
        chk("async_rst_imm", 1, use_imm_w[1], 0);
        chk("async_rst_sext", 0, sext_w[0], 0);
        cycle();
        reset = 1'b1;

        // Randomised traffic against the model
        repeat (500) begin
            drive(rand_inst(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Parametrised pipeline control for the five-stage CPU. Decodes the IF/ID instruction into a control word, carries it through ID/EX, EX/MEM and MEM/WB control registers, and drives per-stage control, operand forwarding selects, load-use stall and branch flush. It sits beside the datapath pipeline registers and is the only source of control for the datapath.

## Interface
Parameters:
- ALUOP_W, 4, width of ALU operation code (codes from Definitions.vh)
- REG_AW, 5, register address width
- BRANCH_IN_MEM, 1, 1: branch resolved in MEM; 0: resolved in EX
- LOAD_USE_STALL, 1, 1: detect load-use hazards and stall; 0: never stall

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ifid_inst  in  32  instruction in IF/ID register
- ext_stall  in  1  memory-wait freeze of the whole pipeline
- branch_taken  in  1  BEQ comparison result from the resolving stage
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  clear IF/ID to zero at next edge
- ex_alu_op  out  ALUOP_W  ALU operation
- ex_use_imm, ex_shift, ex_sign_ext  out  1 each  EX operand controls
- fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 10 EX/MEM, 01 MEM/WB
- mem_write, mem_branch  out  1 each  MEM controls
- wb_reg_write, wb_mem_to_reg  out  1 each  WB controls
- wb_dest  out  REG_AW  WB destination register

## Operation
- Decode (combinational, ifid_inst): R-type 000000 with funct ADD/SUB/AND/OR/NOR/SLT/SLL/SRL/SRA; ADDI, ANDI, ORI, LW, SW, BEQ. Unknown opcode/funct -> all-zero control word (bubble).
- dest = rd for R-type; rt for ADDI/ANDI/ORI/LW; none otherwise. reg_write forced 0 when dest = 0.
- use_imm = 1 for ADDI/ANDI/ORI/LW/SW; shift = 1 for SLL/SRL/SRA; sign_ext = 1 for ADDI/LW/SW/BEQ, 0 for ANDI/ORI.
- Control word (alu_op, use_imm, shift, sign_ext, mem_write, branch, mem_read, reg_write, mem_to_reg, dest, rs, rt) registered into IDEX, then subset into EXMEM, MEMWB each edge.
- Forwarding (combinational, per source rs->fwd_a, rt->fwd_b): 10 if EXMEM.reg_write and EXMEM.dest = src != 0; else 01 if MEMWB.reg_write and MEMWB.dest = src != 0; else 00. EX/MEM wins on double match.
- Load-use (LOAD_USE_STALL=1): hazard = IDEX.mem_read and IDEX.dest != 0 and (IDEX.dest = ifid rs, or = ifid rt when ifid instruction reads rt: R-type, SW, BEQ). Hazard -> pc_write=0, ifid_write=0, bubble into IDEX.
- Flush: taken = branch_taken and resolving-stage branch bit (EXMEM.branch if BRANCH_IN_MEM else IDEX.branch). Taken -> ifid_flush=1, bubble into IDEX; if BRANCH_IN_MEM also bubble into EXMEM. pc_write=1.
- Priority: ext_stall > flush > load-use stall > normal advance.
- ext_stall=1: all control registers hold, pc_write=0, ifid_write=0, ifid_flush=0; branch_taken ignored that cycle.

## Timing
- Reset (async, reset=0): IDEX, EXMEM, MEMWB cleared to bubble; all stage outputs 0, fwd_a=fwd_b=00, wb_dest=0; pc_write=1, ifid_write=1, ifid_flush=0 (combinational on cleared state).
- Instruction decoded in cycle n appears on ex_* in n+1, mem_* in n+2, wb_* in n+3.
- Stall, flush, fwd outputs are combinational from current register state and inputs; no added latency.
- Load-use costs exactly one bubble; hazard clears next cycle because load has moved to EXMEM (forwarding then MEM/WB path one cycle later).
- Branch penalty: 3 cycles (BRANCH_IN_MEM=1), 2 cycles (0).
- Reset released mid-stream: first valid decode takes effect on first rising edge with reset=1.

## Test plan
- Reset: hold reset=0 with random ifid_inst -> all outputs 0 except pc_write=ifid_write=1; release, ADD $3,$1,$2 -> ex_alu_op=ALU_ADD next cycle, wb_reg_write=1, wb_dest=3 after 3 cycles.
- Forwarding: ADD $3,$1,$2 then SUB $4,$3,$3 -> fwd_a=fwd_b=10 while SUB in EX; with one NOP between -> 01; dest $0 -> 00.
- Load-use: LW $5,0($1) then ADD $6,$5,$2 -> one cycle pc_write=ifid_write=0, IDEX bubble; next cycle fwd_a=01 for ADD.
- Branch: BEQ taken, BRANCH_IN_MEM=1 -> ifid_flush=1, next two younger control words zeroed, no mem_write/reg_write from them; repeat with BRANCH_IN_MEM=0 -> one younger zeroed.
- Priority: ext_stall=1 while branch taken and load-use present -> registers hold, pc_write=0, ifid_flush=0; drop ext_stall -> flush occurs, stall suppressed.
- Unknown opcode 111111 and reset=0 asserted mid-pipeline -> bubble; all stage registers clear asynchronously without waiting for clock.
